// File: rtl/i2c_reg_bank.sv
// Register bank, command buffer and TX/RX byte FIFOs for the I2C controller.
// Optional feature macro: I2C_REGBANK_IRQ_EN (CTRL[1] irq_en and the irq output).
module i2c_reg_bank #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       reg_wr,
  input  logic       reg_rd,
  input  logic [3:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic [7:0] reg_rdata,
  output logic       reg_ready,
  output logic       core_en,
  output logic [15:0] prescale,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [4:0] cmd,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       core_busy,
  input  logic       core_done,
  input  logic       core_ack_err,
  input  logic       core_arb_lost,
  output logic       irq
);
  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);

  typedef enum logic {S_IDLE, S_RESP} bus_state_t;

  bus_state_t r_state;
  logic [7:0] r_rdata;
  logic       r_ready;
  logic       r_en;
  logic [7:0] r_presc_lo;
  logic [7:0] r_presc_hi;
  logic       r_cmd_valid;
  logic [4:0] r_cmd;
  logic       r_done;
  logic       r_ack_err;
  logic       r_arb_lost;
  logic [2:0] r_err;

  logic [7:0]   r_tx_mem [TX_DEPTH];
  logic [TXW-1:0] r_tx_wr;
  logic [TXW-1:0] r_tx_rd;
  logic [TXW:0]   r_tx_cnt;
  logic [7:0]   r_rx_mem [RX_DEPTH];
  logic [RXW-1:0] r_rx_wr;
  logic [RXW-1:0] r_rx_rd;
  logic [RXW:0]   r_rx_cnt;

  logic       w_acc, w_wr, w_rd;
  logic       w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic       w_tx_pop, w_tx_push_req, w_tx_push, w_tx_ovf;
  logic       w_rx_pop, w_rx_push, w_rx_ovf;
  logic       w_cmd_wr, w_cmd_ovf, w_flush, w_irq_clr, w_err_wr;
  logic       w_irq_en;
  logic [7:0] w_status;
  logic [7:0] w_rdata;

  // reg_wr wins when both strobes are raised, so an access is a read only without reg_wr
  assign w_acc = (r_state == S_IDLE) && (reg_wr || reg_rd);
  assign w_wr  = w_acc && reg_wr;
  assign w_rd  = w_acc && !reg_wr;

  assign w_tx_full  = (r_tx_cnt == (TXW+1)'(TX_DEPTH));
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == (RXW+1)'(RX_DEPTH));
  assign w_rx_empty = (r_rx_cnt == '0);

  assign w_tx_pop      = tx_ready && !w_tx_empty;
  assign w_tx_push_req = w_wr && (reg_addr == 4'h3);
  assign w_tx_push     = w_tx_push_req && (!w_tx_full || w_tx_pop);
  assign w_tx_ovf      = w_tx_push_req && w_tx_full && !w_tx_pop;
  assign w_rx_pop      = w_rd && (reg_addr == 4'h4) && !w_rx_empty;
  assign w_rx_push     = rx_valid && (!w_rx_full || w_rx_pop);
  assign w_rx_ovf      = rx_valid && w_rx_full && !w_rx_pop;
  assign w_cmd_wr      = w_wr && (reg_addr == 4'h5);
  assign w_cmd_ovf     = w_cmd_wr && r_cmd_valid;
  assign w_flush       = w_wr && (reg_addr == 4'h0) && !reg_wdata[0];
  assign w_irq_clr     = w_wr && (reg_addr == 4'h7);
  assign w_err_wr      = w_wr && (reg_addr == 4'h8);

  assign w_status = {r_arb_lost, r_ack_err, r_done, w_rx_empty, w_tx_empty,
                     w_tx_full, r_cmd_valid, core_busy};

  always_comb begin
    w_rdata = 8'h00;
    case (reg_addr)
      4'h0: w_rdata = {6'b0, w_irq_en, r_en};
      4'h1: w_rdata = r_presc_lo;
      4'h2: w_rdata = r_presc_hi;
      4'h4: w_rdata = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd];
      4'h6: w_rdata = w_status;
      4'h8: w_rdata = {5'b0, r_err};
      default: w_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= reg_wdata;
    if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rdata     <= 8'h00;
      r_ready     <= 1'b0;
      r_en        <= 1'b0;
      r_presc_lo  <= 8'hFF;
      r_presc_hi  <= 8'h00;
      r_cmd_valid <= 1'b0;
      r_cmd       <= 5'h00;
      r_done      <= 1'b0;
      r_ack_err   <= 1'b0;
      r_arb_lost  <= 1'b0;
      r_err       <= 3'b000;
      r_tx_wr     <= '0;
      r_tx_rd     <= '0;
      r_tx_cnt    <= '0;
      r_rx_wr     <= '0;
      r_rx_rd     <= '0;
      r_rx_cnt    <= '0;
    end else begin
      r_state <= w_acc ? S_RESP : S_IDLE;
      r_ready <= w_acc;
      r_rdata <= w_rd ? w_rdata : 8'h00;

      if (w_wr && reg_addr == 4'h0) r_en <= reg_wdata[0];
      if (w_wr && reg_addr == 4'h1) r_presc_lo <= reg_wdata;
      if (w_wr && reg_addr == 4'h2) r_presc_hi <= reg_wdata;

      if (w_cmd_wr && !r_cmd_valid) begin
        r_cmd_valid <= 1'b1;
        r_cmd       <= reg_wdata[4:0];
      end else if (w_flush || (r_cmd_valid && cmd_ready)) begin
        r_cmd_valid <= 1'b0;
      end

      // a core pulse in the same cycle as a clear keeps the flag set
      r_done     <= core_done     | (r_done     & ~(w_irq_clr & reg_wdata[5]));
      r_ack_err  <= core_ack_err  | (r_ack_err  & ~(w_irq_clr & reg_wdata[6]));
      r_arb_lost <= core_arb_lost | (r_arb_lost & ~(w_irq_clr & reg_wdata[7]));
      r_err      <= {w_cmd_ovf, w_rx_ovf, w_tx_ovf} |
                    (r_err & ~(w_err_wr ? reg_wdata[2:0] : 3'b000));

      if (w_flush) begin
        r_tx_wr  <= '0;
        r_tx_rd  <= '0;
        r_tx_cnt <= '0;
        r_rx_wr  <= '0;
        r_rx_rd  <= '0;
        r_rx_cnt <= '0;
      end else begin
        if (w_tx_push) r_tx_wr <= r_tx_wr + TXW'(1);
        if (w_tx_pop)  r_tx_rd <= r_tx_rd + TXW'(1);
        r_tx_cnt <= r_tx_cnt + (TXW+1)'(w_tx_push) - (TXW+1)'(w_tx_pop);
        if (w_rx_push) r_rx_wr <= r_rx_wr + RXW'(1);
        if (w_rx_pop)  r_rx_rd <= r_rx_rd + RXW'(1);
        r_rx_cnt <= r_rx_cnt + (RXW+1)'(w_rx_push) - (RXW+1)'(w_rx_pop);
      end
    end
  end

`ifdef I2C_REGBANK_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && reg_addr == 4'h0) r_irq_en <= reg_wdata[1];
      r_irq <= r_irq_en & (r_done | r_ack_err | r_arb_lost);
    end
  end

  assign w_irq_en = r_irq_en;
  assign irq      = r_irq;
`else
  assign w_irq_en = 1'b0;
  assign irq      = 1'b0;
`endif

  assign reg_rdata = r_rdata;
  assign reg_ready = r_ready;
  assign core_en   = r_en;
  assign prescale  = {r_presc_hi, r_presc_lo};
  assign cmd_valid = r_cmd_valid;
  assign cmd       = r_cmd;
  assign tx_valid  = !w_tx_empty;
  assign tx_data   = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rd];
endmodule

// File: tb/tb_i2c_reg_bank.sv
// Bench for i2c_reg_bank: queue-based reference model checked every cycle plus directed literal checks.
module tb_i2c_reg_bank;
  localparam int TXD = 4;
  localparam int RXD = 4;

  logic clk = 1'b0;
  logic rst_n, reg_wr, reg_rd, cmd_ready, tx_ready, rx_valid;
  logic core_busy, core_done, core_ack_err, core_arb_lost;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata, rx_data;
  logic [7:0] reg_rdata, tx_data;
  logic reg_ready, core_en, cmd_valid, tx_valid, irq;
  logic [15:0] prescale;
  logic [4:0] cmd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  i2c_reg_bank #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst_n(rst_n), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ready(reg_ready),
    .core_en(core_en), .prescale(prescale), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .core_busy(core_busy), .core_done(core_done),
    .core_ack_err(core_ack_err), .core_arb_lost(core_arb_lost), .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: registers as plain variables, FIFOs as queues
  logic m_resp, m_ready, m_en, m_irq_en, m_cmdv, m_done, m_ack, m_arb, m_irq;
  logic [7:0] m_rdata, m_plo, m_phi;
  logic [4:0] m_cmd;
  logic [2:0] m_err;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  task automatic model_step();
    logic acc, is_wr, is_rd, txpop, rxpop, old_cmdv, next_irq;
    logic [7:0] st, rd;
    logic [2:0] err_set;
    if (!rst_n) begin
      m_resp = 0; m_ready = 0; m_rdata = 0; m_en = 0; m_irq_en = 0; m_cmdv = 0; m_cmd = 0;
      m_done = 0; m_ack = 0; m_arb = 0; m_irq = 0; m_err = 0; m_plo = 8'hFF; m_phi = 8'h00;
      txq.delete(); rxq.delete();
      return;
    end
    acc   = !m_resp && (reg_wr || reg_rd);
    is_wr = acc && reg_wr;
    is_rd = acc && !reg_wr;
    st = {m_arb, m_ack, m_done, rxq.size() == 0, txq.size() == 0, txq.size() == TXD, m_cmdv, core_busy};
    rd = 8'h00;
    if (is_rd) begin
      case (reg_addr)
        4'h0: rd = {6'b0, m_irq_en, m_en};
        4'h1: rd = m_plo;
        4'h2: rd = m_phi;
        4'h4: rd = (rxq.size() > 0) ? rxq[0] : 8'h00;
        4'h6: rd = st;
        4'h8: rd = {5'b0, m_err};
        default: rd = 8'h00;
      endcase
    end
    next_irq = m_irq_en && (m_done || m_ack || m_arb);
    err_set = 3'b000;
    txpop = tx_ready && txq.size() > 0;
    rxpop = is_rd && reg_addr == 4'h4 && rxq.size() > 0;
    if (txpop) void'(txq.pop_front());
    if (is_wr && reg_addr == 4'h3) begin
      if (txq.size() < TXD) txq.push_back(reg_wdata); else err_set[0] = 1;
    end
    if (rxpop) void'(rxq.pop_front());
    if (rx_valid) begin
      if (rxq.size() < RXD) rxq.push_back(rx_data); else err_set[1] = 1;
    end
    old_cmdv = m_cmdv;
    if (m_cmdv && cmd_ready) m_cmdv = 0;
    if (is_wr && reg_addr == 4'h5) begin
      if (old_cmdv) err_set[2] = 1;
      else begin m_cmdv = 1; m_cmd = reg_wdata[4:0]; end
    end
    if (is_wr && reg_addr == 4'h7) begin
      if (reg_wdata[5]) m_done = 0;
      if (reg_wdata[6]) m_ack = 0;
      if (reg_wdata[7]) m_arb = 0;
    end
    m_done = m_done | core_done;
    m_ack  = m_ack | core_ack_err;
    m_arb  = m_arb | core_arb_lost;
    if (is_wr && reg_addr == 4'h8) m_err = m_err & ~reg_wdata[2:0];
    m_err = m_err | err_set;
    if (is_wr && reg_addr == 4'h0) begin
      m_en = reg_wdata[0];
`ifdef I2C_REGBANK_IRQ_EN
      m_irq_en = reg_wdata[1];
`endif
      if (!reg_wdata[0]) begin txq.delete(); rxq.delete(); m_cmdv = 0; end
    end
    if (is_wr && reg_addr == 4'h1) m_plo = reg_wdata;
    if (is_wr && reg_addr == 4'h2) m_phi = reg_wdata;
    m_irq = next_irq;
    m_ready = acc;
    m_rdata = rd;
    m_resp = acc;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("reg_ready", {31'b0, reg_ready}, {31'b0, m_ready});
      if (m_ready) check("reg_rdata", {24'b0, reg_rdata}, {24'b0, m_rdata});
      check("core_en", {31'b0, core_en}, {31'b0, m_en});
      check("prescale", {16'b0, prescale}, {16'b0, m_phi, m_plo});
      check("cmd_valid", {31'b0, cmd_valid}, {31'b0, m_cmdv});
      check("cmd", {27'b0, cmd}, {27'b0, m_cmd});
      check("tx_valid", {31'b0, tx_valid}, {31'b0, txq.size() > 0});
      check("tx_data", {24'b0, tx_data}, {24'b0, (txq.size() > 0) ? txq[0] : 8'h00});
      check("irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  // Called on a negedge; returns on a negedge with one idle cycle after the response
  task automatic bus(input logic wr, input logic rd, input logic [3:0] a, input logic [7:0] d,
                     output logic [7:0] q);
    int n;
    reg_wr = wr; reg_rd = rd; reg_addr = a; reg_wdata = d;
    @(negedge clk);
    n = 1;
    while (!reg_ready && n < 4) begin @(negedge clk); n++; end
    check("ready_latency", n, 1);
    q = reg_rdata;
    reg_wr = 0; reg_rd = 0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] q;
    bus(1'b1, 1'b0, a, d, q);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] q;
    bus(1'b0, 1'b1, a, 8'h00, q);
    check(name, {24'b0, q}, {24'b0, exp});
  endtask

  task automatic pulse_rx(input logic [7:0] d);
    rx_valid = 1; rx_data = d;
    @(negedge clk);
    rx_valid = 0;
  endtask

  localparam logic EXP_IRQ =
`ifdef I2C_REGBANK_IRQ_EN
    1'b1;
`else
    1'b0;
`endif

  initial begin
    logic [7:0] q;
    rst_n = 0; reg_wr = 0; reg_rd = 0; reg_addr = 0; reg_wdata = 0; cmd_ready = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0; core_busy = 0; core_done = 0;
    core_ack_err = 0; core_arb_lost = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    check("rst_prescale", {16'b0, prescale}, 32'h00FF);
    check("rst_tx_valid", {31'b0, tx_valid}, 0);
    check("rst_irq", {31'b0, irq}, 0);
    rd_chk("rd_presc_lo", 4'h1, 8'hFF);
    rd_chk("rd_presc_hi", 4'h2, 8'h00);
    rd_chk("rd_status_rst", 4'h6, 8'h18);

    wr(4'h0, 8'h01);
    wr(4'h1, 8'h31);
    check("core_en_set", {31'b0, core_en}, 1);
    check("prescale_31", {16'b0, prescale}, 32'h0031);

    for (int i = 0; i < 5; i++) wr(4'h3, 8'hA0 + 8'(i));
    rd_chk("status_tx_full", 4'h6, 8'h14);
    rd_chk("err_tx_ovf", 4'h8, 8'h01);
    tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check("tx_order", {24'b0, tx_data}, 32'hA0 + i);
      @(negedge clk);
    end
    tx_ready = 0;
    check("tx_drained", {31'b0, tx_valid}, 0);
    wr(4'h8, 8'h01);
    rd_chk("err_cleared", 4'h8, 8'h00);

    wr(4'h5, 8'h09);
    wr(4'h5, 8'h02);
    check("cmd_held", {27'b0, cmd}, 32'h09);
    rd_chk("err_cmd_ovf", 4'h8, 8'h04);
    rd_chk("status_cmdv", 4'h6, 8'h1A);
    cmd_ready = 1;
    @(negedge clk);
    cmd_ready = 0;
    check("cmd_consumed", {31'b0, cmd_valid}, 0);
    wr(4'h8, 8'h04);

    pulse_rx(8'h5A);
    pulse_rx(8'h3C);
    rd_chk("rx_first", 4'h4, 8'h5A);
    rd_chk("rx_second", 4'h4, 8'h3C);
    rd_chk("rx_empty_read", 4'h4, 8'h00);
    rd_chk("status_rx_empty", 4'h6, 8'h18);

    wr(4'h0, 8'h03);
    core_ack_err = 1;
    @(negedge clk);
    core_ack_err = 0;
    @(negedge clk);
    check("irq_after_ack", {31'b0, irq}, {31'b0, EXP_IRQ});
    rd_chk("status_ack", 4'h6, 8'h58);
    reg_wr = 1; reg_addr = 4'h7; reg_wdata = 8'h40; core_ack_err = 1;
    @(negedge clk);
    core_ack_err = 0;
    check("clr_ready", {31'b0, reg_ready}, 1);
    reg_wr = 0;
    @(negedge clk);
    rd_chk("ack_set_wins", 4'h6, 8'h58);
    core_done = 1;
    @(negedge clk);
    core_done = 0;
    rd_chk("status_done", 4'h6, 8'h78);
    wr(4'h7, 8'hE0);
    rd_chk("flags_cleared", 4'h6, 8'h18);

    core_busy = 1; core_arb_lost = 1;
    @(negedge clk);
    core_arb_lost = 0;
    rd_chk("status_arb_busy", 4'h6, 8'h99);
    wr(4'h3, 8'hB0);
    wr(4'h3, 8'hB1);
    pulse_rx(8'hEE);
    wr(4'h5, 8'h11);
    wr(4'h0, 8'h00);
    check("flush_tx", {31'b0, tx_valid}, 0);
    rd_chk("status_flush", 4'h6, 8'h99);
    wr(4'h7, 8'h80);
    core_busy = 0;

    for (int i = 0; i < 5; i++) pulse_rx(8'h10 + 8'(i));
    rd_chk("err_rx_ovf", 4'h8, 8'h02);
    wr(4'h8, 8'h02);
    reg_rd = 1; reg_addr = 4'h4; rx_valid = 1; rx_data = 8'h77;
    @(negedge clk);
    rx_valid = 0;
    check("rx_pop_push", {24'b0, reg_rdata}, 32'h10);
    reg_rd = 0;
    @(negedge clk);
    rd_chk("err_rx_none", 4'h8, 8'h00);
    rd_chk("rx_11", 4'h4, 8'h11);
    rd_chk("rx_12", 4'h4, 8'h12);
    rd_chk("rx_13", 4'h4, 8'h13);
    rd_chk("rx_77", 4'h4, 8'h77);

    for (int i = 0; i < 4; i++) wr(4'h3, 8'hC0 + 8'(i));
    reg_wr = 1; reg_addr = 4'h3; reg_wdata = 8'hC4; tx_ready = 1;
    @(negedge clk);
    tx_ready = 0; reg_wr = 0;
    @(negedge clk);
    rd_chk("err_tx_none", 4'h8, 8'h00);
    check("tx_head_c1", {24'b0, tx_data}, 32'hC1);
    tx_ready = 1;
    repeat (4) @(negedge clk);
    tx_ready = 0;
    check("tx_empty_end", {31'b0, tx_valid}, 0);

    bus(1'b1, 1'b1, 4'h1, 8'h55, q);
    check("wr_rd_rdata", {24'b0, q}, 0);
    check("wr_rd_presc", {16'b0, prescale}, 32'h0055);
    wr(4'hF, 8'hAA);
    rd_chk("unmapped", 4'hF, 8'h00);
    rd_chk("txdata_wo", 4'h3, 8'h00);

    reg_rd = 1; reg_addr = 4'h1; rst_n = 0;
    @(negedge clk);
    check("rst_drop_ready", {31'b0, reg_ready}, 0);
    rst_n = 1; reg_rd = 0;
    @(negedge clk);
    rd_chk("presc_after_rst", 4'h1, 8'hFF);
    check("en_after_rst", {31'b0, core_en}, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
